// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the instruction/data memory arbiter.
package mips_bus_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STREAK_W = 4;

  localparam logic [BE_W-1:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  // One memory-port transfer as seen by the arbiter.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              write;
  } bus_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants while a fetch waits.
module arb_starve_counter
  import mips_bus_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [STREAK_W-1:0] LIMIT_V = STREAK_W'(LIMIT);

  logic [STREAK_W-1:0] count;
  logic [STREAK_W-1:0] count_next;

  // Clear dominates; increment saturates at the limit.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count != LIMIT_V)) begin
      count_next = count + STREAK_W'(1);
    end
  end

  // Counter and registered limit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      at_limit <= 1'b0;
    end else begin
      count    <= count_next;
      at_limit <= (count_next == LIMIT_V);
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Two-master (fetch/data) to one-slave memory arbiter with transfer locking.
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_read,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [DATA_W-1:0] instr_readdata,
  output logic              instr_waitrequest,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_writedata,
  input  logic [BE_W-1:0]   data_byteenable,
  output logic [DATA_W-1:0] data_readdata,
  output logic              data_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest
);

  arb_state_t state;
  arb_state_t state_next;
  bus_req_t   hold;
  bus_req_t   live_req;
  bus_req_t   bus;
  logic       grant_i;
  logic       grant_d;
  logic       owner_i;
  logic       owner_d;
  logic       done;
  logic       at_limit;

  // Idle arbitration: data first unless the fetch has waited long enough.
  always_comb begin
    grant_d  = (state == IDLE) && (data_read || data_write) && !(instr_read && at_limit);
    grant_i  = (state == IDLE) && instr_read && !grant_d;
    owner_i  = grant_i || (state == LOCK_I);
    owner_d  = grant_d || (state == LOCK_D);
    done     = (owner_i || owner_d) && !mem_waitrequest;
    live_req = '{address: instr_address, writedata: '0,
                 byteenable: BYTEEN_ALL, write: 1'b0};
    if (grant_d) begin
      live_req = '{address: data_address, writedata: data_writedata,
                   byteenable: data_byteenable, write: data_write};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: lock on a stalled grant, release on completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d && mem_waitrequest) begin
          state_next = LOCK_D;
        end else if (grant_i && mem_waitrequest) begin
          state_next = LOCK_I;
        end
      end
      LOCK_I, LOCK_D: begin
        if (!mem_waitrequest) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port and per-master stalls; reset forces the port quiet.
  always_comb begin
    bus               = (state == IDLE) ? live_req : hold;
    mem_address       = bus.address;
    mem_writedata     = bus.writedata;
    mem_byteenable    = bus.byteenable;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    instr_waitrequest = 1'b1;
    data_waitrequest  = 1'b1;
    instr_readdata    = mem_readdata;
    data_readdata     = mem_readdata;
    if (reset && (owner_i || owner_d)) begin
      mem_read          = !bus.write;
      mem_write         = bus.write;
      instr_waitrequest = !(owner_i && !mem_waitrequest);
      data_waitrequest  = !(owner_d && !mem_waitrequest);
    end
  end

  // Capture the granted request so a locked transfer ignores live inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (grant_i || grant_d) begin
      hold <= live_req;
    end
  end

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_streak (
    .clk     (clk),
    .reset   (reset),
    .clr     (!instr_read || (owner_i && done)),
    .inc     (owner_d && done && instr_read),
    .at_limit(at_limit)
  );

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized bench for mips_mem_arbiter against a transfer-level model.
module tb_mips_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  mips_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_read       (instr_read),
    .instr_address    (instr_address),
    .instr_readdata   (instr_readdata),
    .instr_waitrequest(instr_waitrequest),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_address     (data_address),
    .data_writedata   (data_writedata),
    .data_byteenable  (data_byteenable),
    .data_readdata    (data_readdata),
    .data_waitrequest (data_waitrequest),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_readdata     (mem_readdata),
    .mem_waitrequest  (mem_waitrequest)
  );

  always #5 clk = ~clk;

  // Unified memory slave (word index from address bits 7:2).
  logic [31:0] mem  [0:63];
  logic [31:0] smem [0:63];
  assign mem_readdata = mem[mem_address[7:2]];

  always @(posedge clk) begin : slave_wr
    logic [31:0] w;
    if (reset && mem_write && !mem_waitrequest) begin
      w = mem[mem_address[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
      mem[mem_address[7:2]] <= w;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: owner of a locked transfer (0 none, 1 fetch, 2 data).
  int          own;
  int          streak;
  logic [31:0] l_addr, l_wdata;
  logic [3:0]  l_be;
  logic        l_wr;

  task automatic model_reset();
    own = 0;
    streak = 0;
    l_addr = '0; l_wdata = '0; l_be = '0; l_wr = 1'b0;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                       input logic mw);
    instr_read = ir; instr_address = ia;
    data_read = dr; data_write = dw; data_address = da;
    data_writedata = dwd; data_byteenable = dbe;
    mem_waitrequest = mw;
  endtask

  // One cycle: inputs set at negedge; check outputs, then advance model at posedge.
  task automatic cyc(output int who);
    logic        ireq, dreq, wr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    int          cur;
    #1;
    ireq = instr_read;
    dreq = data_read || data_write;
    cur = own; a = l_addr; wd = l_wdata; be = l_be; wr = l_wr;
    if (own == 0) begin
      if (dreq && !(ireq && streak == LIMIT)) cur = 2;
      else if (ireq) cur = 1;
      else cur = 0;
      if (cur == 1) begin a = instr_address; wd = '0; be = 4'hF; wr = 1'b0; end
      if (cur == 2) begin a = data_address; wd = data_writedata; be = data_byteenable; wr = data_write; end
    end
    check("mem_read", 32'(mem_read), 32'(cur != 0 && !wr));
    check("mem_write", 32'(mem_write), 32'(cur != 0 && wr));
    check("instr_wait", 32'(instr_waitrequest), 32'(!(cur == 1 && !mem_waitrequest)));
    check("data_wait", 32'(data_waitrequest), 32'(!(cur == 2 && !mem_waitrequest)));
    if (cur != 0) begin
      check("mem_address", mem_address, a);
      check("mem_byteen", 32'(mem_byteenable), 32'(be));
      if (wr) check("mem_wdata", mem_writedata, wd);
      if (!mem_waitrequest && !wr) begin
        if (cur == 1) check("instr_rdata", instr_readdata, smem[a[7:2]]);
        else          check("data_rdata", data_readdata, smem[a[7:2]]);
      end
    end
    @(posedge clk);
    who = 0;
    if (cur != 0 && !mem_waitrequest) begin
      who = cur;
      if (wr)
        for (int b = 0; b < 4; b++)
          if (be[b]) smem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
      own = 0;
    end else if (cur != 0) begin
      own = cur; l_addr = a; l_wdata = wd; l_be = be; l_wr = wr;
    end
    if (!ireq) streak = 0;
    else if (who == 1) streak = 0;
    else if (who == 2 && streak < LIMIT) streak++;
    @(negedge clk);
  endtask

  int who;
  int pat [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  logic        i_pend, d_pend, d_w, d_both;
  logic [31:0] i_a, d_a, d_wd;
  logic [3:0]  d_be;

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem[k] = $urandom;
      smem[k] = mem[k];
    end
    model_reset();
    reset = 1'b0;
    drive(1, 32'h80, 1, 1, 32'h40, 32'h1234, 4'hF, 1'b0);
    #1;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_instr_wait", 32'(instr_waitrequest), 32'd1);
    check("rst_data_wait", 32'(data_waitrequest), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Both masters continuously pending with zero-wait memory.
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h80, 1, 0, 32'h40, 32'h0, 4'hF, 1'b0);
      cyc(who);
      check("grant_order", 32'(who), 32'(pat[k]));
    end

    // Fetch-only, zero wait, one per cycle.
    drive(1, 32'hBFC0_0000, 0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(who); check("fetch0_done", 32'(who), 32'd1);
    drive(1, 32'hBFC0_0004, 0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(who); check("fetch1_done", 32'(who), 32'd1);

    // Stalled store with live inputs disturbed while locked.
    drive(0, 32'h0, 0, 1, 32'h1000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    cyc(who);
    for (int k = 0; k < 2; k++) begin
      drive(0, 32'h0, 0, 1, $urandom, $urandom, 4'(($urandom)), 1'b1);
      cyc(who);
      check("store_locked", 32'(who), 32'd0);
    end
    drive(0, 32'h0, 0, 1, 32'h1000, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    cyc(who); check("store_done", 32'(who), 32'd2);

    // Fetch arrives while a load is locked; granted right after.
    drive(0, 32'h0, 1, 0, 32'h20, 32'h0, 4'hF, 1'b1);
    cyc(who);
    drive(1, $urandom, 1, 0, 32'h20, 32'h0, 4'hF, 1'b1);
    cyc(who);
    drive(1, $urandom, 1, 0, 32'h20, 32'h0, 4'hF, 1'b0);
    cyc(who); check("load_done", 32'(who), 32'd2);
    drive(1, 32'h64, 0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(who); check("handover", 32'(who), 32'd1);

    // Read and write together behave as a write.
    drive(0, 32'h0, 1, 1, 32'h30, 32'hCAFE_F00D, 4'b1100, 1'b0);
    cyc(who); check("rw_done", 32'(who), 32'd2);

    // Reset in the middle of a locked fetch.
    drive(1, 32'h44, 0, 0, 32'h0, 32'h0, 4'h0, 1'b1);
    cyc(who);
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_instr_wait", 32'(instr_waitrequest), 32'd1);
    check("midrst_data_wait", 32'(data_waitrequest), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 32'h44, 1, 0, 32'h48, 32'h0, 4'hF, 1'b0);
    cyc(who); check("post_rst_grant", 32'(who), 32'd2);

    // Random traffic from two protocol-following masters.
    i_pend = 1'b0; d_pend = 1'b0;
    i_a = '0; d_a = '0; d_wd = '0; d_be = '0; d_w = 1'b0; d_both = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!i_pend && ($urandom % 3 == 0)) begin
        i_pend = 1'b1; i_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && ($urandom % 2 == 0)) begin
        d_pend = 1'b1; d_a = $urandom & 32'hFFFF_FFFC;
        d_w = 1'($urandom); d_both = ($urandom % 8 == 0);
        d_wd = $urandom; d_be = 4'($urandom_range(1, 15));
      end
      instr_read = i_pend;
      instr_address = (!i_pend || (own == 1 && $urandom % 2 == 0)) ? $urandom : i_a;
      data_read = d_pend && (!d_w || d_both);
      data_write = d_pend && d_w;
      data_address = (!d_pend || (own == 2 && $urandom % 2 == 0)) ? $urandom : d_a;
      data_writedata = (own == 2 && $urandom % 2 == 0) ? $urandom : d_wd;
      data_byteenable = d_be;
      mem_waitrequest = ($urandom % 3 == 0);
      cyc(who);
      if (who == 1) i_pend = 1'b0;
      if (who == 2) d_pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
